// File: rtl/acumulador_alu_seq.sv
`default_nettype none
// ============================================================================
// acumulador_alu_seq : registered accumulator ALU with a valid/ready command
//   handshake and bit-serial shifts. Define ACUM_SATURATE_EN to clamp add/sub.
// Revision: 1.0
// ============================================================================
module acumulador_alu_seq #(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              op,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] acc,
    output logic                    done,
    output logic                    zero,
    output logic                    neg,
    output logic                    carry,
    output logic                    ovf,
    output logic                    err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ASR  = 4'd7;
    localparam logic [3:0] OP_LOAD = 4'd8;
    localparam logic [3:0] OP_CLR  = 4'd9;

`ifdef ACUM_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic [WIDTH-1:0]   w_sat;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_res;
    logic [SHAMT_W-1:0] w_shamt;

    assign w_shamt   = b[SHAMT_W-1:0];
    assign w_sum     = {1'b0, acc_q} + {1'b0, b};
    assign w_dif     = {1'b0, acc_q} - {1'b0, b};
    assign w_add_ovf = (acc_q[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != acc_q[WIDTH-1]);
    assign w_sub_ovf = (acc_q[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != acc_q[WIDTH-1]);
    // On overflow the true result lies beyond the range on the side of acc's sign.
    assign w_sat     = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign w_shifted = dir_q ? {acc_q[WIDTH-1], acc_q[WIDTH-1:1]} : {acc_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        w_res   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    done_d  = 1'b1;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    case (op)
                        OP_ADD: begin
                            w_res   = (SAT_EN && w_add_ovf) ? w_sat : w_sum[WIDTH-1:0];
                            carry_d = w_sum[WIDTH];
                            ovf_d   = w_add_ovf;
                        end
                        OP_SUB: begin
                            w_res   = (SAT_EN && w_sub_ovf) ? w_sat : w_dif[WIDTH-1:0];
                            carry_d = w_dif[WIDTH];
                            ovf_d   = w_sub_ovf;
                        end
                        OP_AND:  w_res = acc_q & b;
                        OP_OR:   w_res = acc_q | b;
                        OP_XOR:  w_res = acc_q ^ b;
                        OP_NOT:  w_res = ~acc_q;
                        OP_SHL, OP_ASR: begin
                            // Zero-length shifts retire immediately with acc unchanged.
                            if (w_shamt != '0) begin
                                state_d = ST_SHIFT;
                                cnt_d   = w_shamt;
                                dir_d   = op[0];
                                done_d  = 1'b0;
                                carry_d = carry_q;
                                ovf_d   = ovf_q;
                                err_d   = err_q;
                            end
                        end
                        OP_LOAD: w_res = b;
                        OP_CLR:  w_res = '0;
                        default: begin
                            err_d   = 1'b1;
                            carry_d = carry_q;
                            ovf_d   = ovf_q;
                        end
                    endcase
                    acc_d  = w_res;
                    zero_d = (w_res == '0);
                    neg_d  = w_res[WIDTH-1];
                end
            end
            ST_SHIFT: begin
                acc_d = w_shifted;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    zero_d  = (w_shifted == '0);
                    neg_d   = w_shifted[WIDTH-1];
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign acc      = acc_q;
    assign done     = done_q;
    assign zero     = zero_q;
    assign neg      = neg_q;
    assign carry    = carry_q;
    assign ovf      = ovf_q;
    assign err      = err_q;

endmodule
`default_nettype wire
